prio_seg_display: RTL and testbench

- Consumer stage directly downstream of the 8-to-3 priority encoder in the board example.
- Takes the encoder's code `y[2:0]` and valid flag `f`, and filters out transient changes with a stability qualifier.
- Keeps a 4-deep history of accepted results and drives four 7-segment digits: newest value on digit 0, older values on digits 1..3.
- Also provides an update counter and a valid LED.

---
 rtl/prio_seg_display_pkg.sv | 25 ++
 rtl/prio_seg_display_if.sv | 33 +++
 rtl/prio_seg_display_seg7_dec.sv | 20 ++
 rtl/prio_seg_display.sv | 114 +++++++++++
 tb/tb_prio_seg_display.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/prio_seg_display_pkg.sv
// prio_disp_pkg: types and constants shared by the priority-code display
// stage.
//   state_t  - qualifier FSM states (HOLD, QUAL)
//   entry_t  - one history slot {valid, f, y}
//   SEG_*    - active-low 7-segment glyphs (bit0=a .. bit6=g, bit7=dp)
package prio_disp_pkg;

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    QUAL = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       f;
    logic [2:0] y;
  } entry_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_HEX [0:7] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8
  };

endpackage

// File: rtl/prio_seg_display_if.sv
// prio_seg_display_if: bundles the encoder-facing inputs and the display
// outputs of prio_seg_display.
//   en, y, f              - qualifier enable, encoder code, encoder valid
//   seg0..seg3            - active-low digits, seg0 newest
//   led_valid, upd_cnt    - f of the latest accepted pair, update counter
//   dbg_state             - current qualifier FSM state
// master: stimulus side (drives en/y/f). slave: the display stage.
// There is no handshake: {f,y} is sampled unconditionally on every edge.
interface prio_seg_display_if;
  import prio_disp_pkg::*;

  logic       en;
  logic [2:0] y;
  logic       f;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic       led_valid;
  logic [7:0] upd_cnt;
  state_t     dbg_state;

  modport master (
    output en, y, f,
    input  seg0, seg1, seg2, seg3, led_valid, upd_cnt, dbg_state
  );

  modport slave (
    input  en, y, f,
    output seg0, seg1, seg2, seg3, led_valid, upd_cnt, dbg_state
  );

endinterface

// File: rtl/prio_seg_display_seg7_dec.sv
// seg7_dec: combinational decode of one history entry to an active-low glyph.
//   e   - history entry {valid, f, y}
//   seg - glyph; blank if invalid, dash if f=0, hex digit of y otherwise.
//         The decimal point is always off.
module seg7_dec
  import prio_disp_pkg::*;
(
  input  entry_t     e,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (e.valid) begin
      if (e.f) seg = SEG_HEX[e.y];
      else     seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/prio_seg_display.sv
// prio_seg_display: stability-qualified consumer of an 8-to-3 priority
// encoder. A new {f,y} pair is accepted on its STABLE_CYCLES-th consecutive
// sampling edge; accepted pairs are pushed into a 4-deep history shown on
// four 7-segment digits (seg0 newest).
//   clk, rst - clock, synchronous active-high reset
//   bus      - prio_seg_display_if.slave (en, y, f in; digits, led_valid,
//              upd_cnt, dbg_state out)
module prio_seg_display
  import prio_disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int HIST_DEPTH    = 4
) (
  input logic                clk,
  input logic                rst,
  prio_seg_display_if.slave  bus
);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] cand, cand_n;
  logic [3:0] acc;
  logic       accept;
  logic [3:0] samp;
  logic [8:0] cnt_inc;
  entry_t     hist [HIST_DEPTH];
  logic       led_q;
  logic [7:0] upd_q;

  assign samp    = {bus.f, bus.y};
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  // Next-state logic. Whenever accept is raised the sample equals the
  // candidate being accepted, so the sample itself is what gets committed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (!bus.en) begin
      state_n = HOLD;
      cnt_n   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (samp != acc) begin
            cand_n = samp;
            if (STABLE_CYCLES == 1) begin
              accept = 1'b1;
              cnt_n  = '0;
            end else begin
              cnt_n   = 8'd1;
              state_n = QUAL;
            end
          end
        end
        QUAL: begin
          if (samp == cand) begin
            if (cnt_inc >= 9'(STABLE_CYCLES)) begin
              accept  = 1'b1;
              cnt_n   = '0;
              state_n = HOLD;
            end else begin
              cnt_n = cnt_inc[7:0];
            end
          end else if (samp == acc) begin
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            cand_n = samp;
            cnt_n  = 8'd1;
          end
        end
        default: begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
      cnt   <= '0;
      cand  <= '0;
      acc   <= '0;
      led_q <= 1'b0;
      upd_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
      if (accept) begin
        acc     <= samp;
        led_q   <= samp[3];
        upd_q   <= upd_q + 8'd1;
        hist[0] <= '{valid: 1'b1, f: samp[3], y: samp[2:0]};
        for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
      end
    end
  end

  seg7_dec u_dec0 (.e(hist[0]), .seg(bus.seg0));
  seg7_dec u_dec1 (.e(hist[1]), .seg(bus.seg1));
  seg7_dec u_dec2 (.e(hist[2]), .seg(bus.seg2));
  seg7_dec u_dec3 (.e(hist[3]), .seg(bus.seg3));

  assign bus.led_valid = led_q;
  assign bus.upd_cnt   = upd_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_prio_seg_display.sv
// tb_prio_seg_display: directed bench for prio_seg_display (STABLE_CYCLES=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_prio_seg_display;
  import prio_disp_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  prio_seg_display_if bus ();

  prio_seg_display #(.STABLE_CYCLES(4), .HIST_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, land 1 ns after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [2:0] y);
    bus.f = f;
    bus.y = y;
  endtask

  task automatic chk_digits(input string tag, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3);
    chk({tag, ".seg0"}, 32'(bus.seg0), 32'(d0));
    chk({tag, ".seg1"}, 32'(bus.seg1), 32'(d1));
    chk({tag, ".seg2"}, 32'(bus.seg2), 32'(d2));
    chk({tag, ".seg3"}, 32'(bus.seg3), 32'(d3));
  endtask

  initial begin
    logic [2:0] seq [5];
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.en  = 1'b1;
    drive(1'b0, 3'd0);
    step(2);
    rst = 1'b0;

    // reset state held under idle input
    step(10);
    chk_digits("idle", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    chk("idle.led", 32'(bus.led_valid), 32'd0);
    chk("idle.cnt", 32'(bus.upd_cnt), 32'd0);
    chk("idle.state", 32'(bus.dbg_state), 32'(HOLD));

    // first accept lands on the 4th edge, not the 3rd
    drive(1'b1, 3'd5);
    step(3);
    chk("y5.edge3.seg0", 32'(bus.seg0), 32'hFF);
    chk("y5.edge3.cnt", 32'(bus.upd_cnt), 32'd0);
    chk("y5.edge3.state", 32'(bus.dbg_state), 32'(QUAL));
    step(1);
    chk_digits("y5.edge4", 8'h92, 8'hFF, 8'hFF, 8'hFF);
    chk("y5.edge4.cnt", 32'(bus.upd_cnt), 32'd1);
    chk("y5.edge4.led", 32'(bus.led_valid), 32'd1);

    // short glitch back to the accepted value
    drive(1'b1, 3'd3);
    step(2);
    drive(1'b1, 3'd5);
    step(6);
    chk("glitch.seg0", 32'(bus.seg0), 32'h92);
    chk("glitch.cnt", 32'(bus.upd_cnt), 32'd1);

    // 3/6 alternating every 2 cycles never qualifies
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 1) ? 3'd6 : 3'd3);
      step(2);
    end
    drive(1'b1, 3'd5);
    step(4);
    chk("toggle.seg0", 32'(bus.seg0), 32'h92);
    chk("toggle.cnt", 32'(bus.upd_cnt), 32'd1);

    // sequence 5,3,7,0,2 each 6 cycles; 5 is already accepted
    seq = '{3'd5, 3'd3, 3'd7, 3'd0, 3'd2};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i]);
      step(6);
    end
    chk_digits("seq", 8'hA4, 8'hC0, 8'hF8, 8'hB0);
    chk("seq.cnt", 32'(bus.upd_cnt), 32'd5);

    // en=0 freezes acceptance
    bus.en = 1'b0;
    drive(1'b1, 3'd6);
    step(10);
    chk("en0.seg0", 32'(bus.seg0), 32'hA4);
    chk("en0.cnt", 32'(bus.upd_cnt), 32'd5);
    bus.en = 1'b1;
    step(3);
    chk("en1.edge3.cnt", 32'(bus.upd_cnt), 32'd5);
    step(1);
    chk_digits("en1.edge4", 8'h82, 8'hA4, 8'hC0, 8'hF8);
    chk("en1.edge4.cnt", 32'(bus.upd_cnt), 32'd6);

    // f=0 with nonzero y shows a dash; steady input never re-pushes
    drive(1'b0, 3'd3);
    step(4);
    chk_digits("dash", 8'hBF, 8'h82, 8'hA4, 8'hC0);
    chk("dash.led", 32'(bus.led_valid), 32'd0);
    chk("dash.cnt", 32'(bus.upd_cnt), 32'd7);
    step(10);
    chk("steady.cnt", 32'(bus.upd_cnt), 32'd7);

    // reset in the middle of qualification discards the candidate
    drive(1'b1, 3'd1);
    step(2);
    chk("midq.state", 32'(bus.dbg_state), 32'(QUAL));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_digits("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    chk("rst.led", 32'(bus.led_valid), 32'd0);
    chk("rst.cnt", 32'(bus.upd_cnt), 32'd0);
    chk("rst.state", 32'(bus.dbg_state), 32'(HOLD));
    step(3);
    chk("post_rst.edge3.cnt", 32'(bus.upd_cnt), 32'd0);
    step(1);
    chk("post_rst.edge4.cnt", 32'(bus.upd_cnt), 32'd1);
    chk("post_rst.edge4.seg0", 32'(bus.seg0), 32'hF9);

    // drive the counter to 255, then wrap
    for (int k = 1; k <= 254; k++) begin
      drive(1'b1, (k % 2 == 1) ? 3'd2 : 3'd1);
      step(4);
    end
    chk("wrap.255", 32'(bus.upd_cnt), 32'd255);
    drive(1'b1, 3'd2);
    step(4);
    chk("wrap.0", 32'(bus.upd_cnt), 32'd0);
    chk("wrap.seg0", 32'(bus.seg0), 32'hA4);
    chk("wrap.seg1", 32'(bus.seg1), 32'hF9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
